// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count, sticky overflow/underflow flags and a synchronous flush.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through. In that mode
// data_out shows the head entry combinationally whenever the FIFO is not
// empty, and r_en pops it. Without the macro, reads are registered: data_out
// updates on the edge that accepts the read and holds until the next one.
//
// Parameters:
//   DEPTH       number of entries (>= 2, any integer)
//   DATA_WIDTH  bits per entry
//   AF_LEVEL    almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   w_en, r_en              write / read requests
//   flush                   synchronous clear of contents (beats w_en/r_en)
//   clr_err                 synchronous clear of overflow/underflow
//   data_in / data_out      write data / read data
//   full, empty             count == DEPTH / count == 0
//   almost_full/_empty      threshold decodes of count
//   count                   current occupancy
//   overflow, underflow     sticky misuse flags
module sync_fifo_flags #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          w_en,
   input  logic                          r_en,
   input  logic                          flush,
   input  logic                          clr_err,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] LP_LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr;
   logic                  w_rd;
   logic [PW-1:0]         w_wptr_nxt;
   logic [PW-1:0]         w_rptr_nxt;

   // Flags decode the registered count only, so no request input reaches
   // an output combinationally.
   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // Gating on the registered flags means no write-through when empty and
   // only the read proceeds when full.
   assign w_wr = w_en && !w_full  && !flush;
   assign w_rd = r_en && !w_empty && !flush;

   // Explicit wrap so non-power-of-two depths work.
   assign w_wptr_nxt = (r_wptr == LP_LAST) ? '0 : r_wptr + PW'(1);
   assign w_rptr_nxt = (r_rptr == LP_LAST) ? '0 : r_rptr + PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= w_wptr_nxt;
         if (w_rd) r_rptr <= w_rptr_nxt;
         if (w_wr && !w_rd)
            r_count <= r_count + CW'(1);
         else if (w_rd && !w_wr)
            r_count <= r_count - CW'(1);
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr) r_mem[r_wptr] <= data_in;
   end

   // A new error in the same cycle as clr_err wins, so the flag stays set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_ovf <= (w_en && w_full  && !flush) || (r_ovf && !clr_err);
         r_unf <= (r_en && w_empty && !flush) || (r_unf && !clr_err);
      end
   end

`ifdef FIFO_FWFT_EN
   assign data_out = r_mem[r_rptr];
`else
   logic [DATA_WIDTH-1:0] r_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_dout <= '0;
      else if (w_rd)
         r_dout <= r_mem[r_rptr];
   end

   assign data_out = r_dout;
`endif

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags (DEPTH=8, DATA_WIDTH=8, AF=6, AE=2).
// A queue-based model tracks contents, occupancy and sticky flags; each
// scenario task drives cycles and compares the packed output vector.
module tb_sync_fifo_flags;

   localparam int DEPTH = 8;
   localparam int DW    = 8;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          w_en, r_en, flush, clr_err;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          full, empty, almost_full, almost_empty;
   logic [3:0]    count;
   logic          overflow, underflow;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_dout;
   logic          m_ovf, m_unf;

   logic [17:0]   obs, exp_v, msk;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .flush(flush),
      .clr_err(clr_err), .data_in(data_in), .data_out(data_out),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   assign obs = {count, full, empty, almost_full, almost_empty,
                 overflow, underflow, data_out};

   function automatic logic [17:0] exp_vec();
      int n = m_q.size();
      logic [DW-1:0] d;
`ifdef FIFO_FWFT_EN
      d = (n > 0) ? m_q[0] : '0;
`else
      d = m_dout;
`endif
      return {4'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf, d};
   endfunction

   function automatic logic [17:0] exp_mask();
`ifdef FIFO_FWFT_EN
      if (m_q.size() == 0) return {10'h3ff, 8'h00};
`endif
      return '1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // One clock cycle: drive at negedge, advance the model, return at posedge+1.
   task automatic cyc(input logic we, input logic re, input logic fl,
                      input logic ce, input logic [DW-1:0] d);
      bit is_full, is_empty, wacc, racc;
      @(negedge clk);
      w_en = we; r_en = re; flush = fl; clr_err = ce; data_in = d;
      is_full  = (m_q.size() == DEPTH);
      is_empty = (m_q.size() == 0);
      wacc = we && !is_full  && !fl;
      racc = re && !is_empty && !fl;
      m_ovf = (we && is_full  && !fl) || (m_ovf && !ce);
      m_unf = (re && is_empty && !fl) || (m_unf && !ce);
      if (fl) m_q.delete();
      else begin
         if (racc) m_dout = m_q.pop_front();
         if (wacc) m_q.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; w_en = 0; r_en = 0; flush = 0; clr_err = 0; data_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk)) begin
         n_fail++;
         $display("FAIL reset: got %h expected %h", obs, exp_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if ({count, empty, full} !== {4'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release: got %h/%b/%b expected 0/1/0",
                  count, empty, full);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH + 1; i++) begin
         cyc(1, 0, 0, 0, 8'($urandom));
         exp_v = exp_vec(); msk = exp_mask(); n_chk++;
         if ((obs & msk) !== (exp_v & msk)) begin
            n_fail++;
            $display("FAIL fill_overflow w%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      n_chk++;
      if ({count, full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL overflow_final: got cnt=%0d full=%b ovf=%b expected 8/1/1",
                  count, full, overflow);
      end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < DEPTH + 1; i++) begin
         cyc(0, 1, 0, 0, 8'h00);
         exp_v = exp_vec(); msk = exp_mask(); n_chk++;
         if ((obs & msk) !== (exp_v & msk)) begin
            n_fail++;
            $display("FAIL drain_underflow r%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      n_chk++;
      if ({empty, underflow} !== 2'b11) begin
         n_fail++;
         $display("FAIL underflow_final: got empty=%b unf=%b expected 1/1",
                  empty, underflow);
      end
   endtask

   task automatic test_back_to_back();
      cyc(0, 0, 0, 1, 8'h00);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'($urandom));
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0, 0, 8'($urandom));
         exp_v = exp_vec(); msk = exp_mask(); n_chk++;
         if ((obs & msk) !== (exp_v & msk)) begin
            n_fail++;
            $display("FAIL back_to_back c%0d: got %h expected %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_full_empty_both();
      while (m_q.size() < DEPTH) cyc(1, 0, 0, 0, 8'($urandom));
      cyc(1, 1, 0, 0, 8'hA5);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk) || count !== 4'd7) begin
         n_fail++;
         $display("FAIL full_both: got %h expected %h", obs, exp_v);
      end
      while (m_q.size() > 0) cyc(0, 1, 0, 0, 8'h00);
      cyc(1, 1, 0, 0, 8'h5A);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk) || count !== 4'd1) begin
         n_fail++;
         $display("FAIL empty_both: got %h expected %h", obs, exp_v);
      end
      cyc(0, 1, 0, 0, 8'h00);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk)) begin
         n_fail++;
         $display("FAIL empty_both_readback: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_flush_clr();
      cyc(0, 0, 0, 1, 8'h00);
      while (m_q.size() < DEPTH + 1 && !m_ovf) cyc(1, 0, 0, 0, 8'($urandom));
      repeat (3) cyc(0, 1, 0, 0, 8'h00);
      cyc(1, 0, 1, 0, 8'h77);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk) || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL flush: got %h expected %h", obs, exp_v);
      end
      cyc(0, 1, 0, 0, 8'h00);
      // new underflow coincides with clr_err: flag must stay, overflow clears
      cyc(0, 1, 0, 1, 8'h00);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk)) begin
         n_fail++;
         $display("FAIL clr_err_collide: got %h expected %h", obs, exp_v);
      end
      cyc(0, 0, 0, 1, 8'h00);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk) || {overflow, underflow} !== 2'b00) begin
         n_fail++;
         $display("FAIL clr_err: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
             ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
             8'($urandom));
         exp_v = exp_vec(); msk = exp_mask(); n_chk++;
         if ((obs & msk) !== (exp_v & msk)) begin
            n_fail++;
            $display("FAIL random c%0d: got %h expected %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'($urandom));
      cyc(1, 1, 0, 0, 8'($urandom));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk)) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs, exp_v);
      end
      @(negedge clk);
      w_en = 0; r_en = 0; flush = 0; clr_err = 0;
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 8'h3C);
      cyc(0, 1, 0, 0, 8'h00);
      exp_v = exp_vec(); msk = exp_mask(); n_chk++;
      if ((obs & msk) !== (exp_v & msk)) begin
         n_fail++;
         $display("FAIL after_reset: got %h expected %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_back_to_back();
      test_full_empty_both();
      test_flush_clr();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
